// File: rtl/gpr_arbiter_pkg.sv
// Shared types and constants for the GPR arbiter.
//   state_e    : issue FSM states (idle, core issue, debug issue)
//   REG_ADDR_W : register address width
//   XLEN       : register data width
//   REG_X0     : hard-wired zero register address
package gpr_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StIssueCore = 2'd1,
    StIssueDbg  = 2'd2
  } state_e;

endpackage

// File: rtl/gpr_arbiter_if.sv
// Bundle of all requester and register-file signals around the GPR arbiter.
//   slave  : arbiter view (requests in, grants/read data/gpr controls out)
//   master : environment view (core, debug unit and gpr model)
// Optional macro GPR_ARBITER_LOCK_EN adds dbg_lock.
interface gpr_arbiter_if;
  import gpr_arbiter_pkg::*;

  logic                  core_valid;
  logic                  core_ready;
  logic [REG_ADDR_W-1:0] core_ra;
  logic [REG_ADDR_W-1:0] core_rb;
  logic [REG_ADDR_W-1:0] core_rd;
  logic                  core_we;
  logic [XLEN-1:0]       core_wdata;
  logic [XLEN-1:0]       core_qa;
  logic [XLEN-1:0]       core_qb;
  logic                  core_rvalid;

  logic                  dbg_valid;
  logic                  dbg_ready;
  logic [REG_ADDR_W-1:0] dbg_addr;
  logic                  dbg_we;
  logic [XLEN-1:0]       dbg_wdata;
  logic [XLEN-1:0]       dbg_rdata;
  logic                  dbg_rvalid;
`ifdef GPR_ARBITER_LOCK_EN
  logic                  dbg_lock;
`endif

  logic [REG_ADDR_W-1:0] gpr_ra;
  logic [REG_ADDR_W-1:0] gpr_rb;
  logic [REG_ADDR_W-1:0] gpr_rd;
  logic                  gpr_we;
  logic [XLEN-1:0]       gpr_di;
  logic [XLEN-1:0]       gpr_qa;
  logic [XLEN-1:0]       gpr_qb;

  modport slave (
    input  core_valid, core_ra, core_rb, core_rd, core_we, core_wdata,
    output core_ready, core_qa, core_qb, core_rvalid,
    input  dbg_valid, dbg_addr, dbg_we, dbg_wdata,
`ifdef GPR_ARBITER_LOCK_EN
    input  dbg_lock,
`endif
    output dbg_ready, dbg_rdata, dbg_rvalid,
    output gpr_ra, gpr_rb, gpr_rd, gpr_we, gpr_di,
    input  gpr_qa, gpr_qb
  );

  modport master (
    output core_valid, core_ra, core_rb, core_rd, core_we, core_wdata,
    input  core_ready, core_qa, core_qb, core_rvalid,
    output dbg_valid, dbg_addr, dbg_we, dbg_wdata,
`ifdef GPR_ARBITER_LOCK_EN
    output dbg_lock,
`endif
    input  dbg_ready, dbg_rdata, dbg_rvalid,
    input  gpr_ra, gpr_rb, gpr_rd, gpr_we, gpr_di,
    output gpr_qa, gpr_qb
  );

endinterface

// File: rtl/gpr_arbiter_starve.sv
// Saturating wait counter used to detect debug starvation.
//   clk, rst_n : clock, async active-low reset
//   inc_i      : count one more waiting cycle (saturates at STARVE_MAX)
//   clr_i      : return to zero (wins over inc_i)
//   at_max_o   : counter equals STARVE_MAX
module gpr_arbiter_starve #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpr_arbiter.sv
// Arbitrates the single GPR file between the core pipeline and the debug unit.
// Core has fixed priority; debug preempts after STARVE_MAX waiting cycles.
// Each accepted request is issued to the gpr in the following cycle and its
// read data is returned with an rvalid pulse one cycle after that.
//   clk, rst_n : clock, async active-low reset
//   bus        : gpr_arbiter_if.slave (core/debug handshakes, gpr controls)
// Optional macro GPR_ARBITER_LOCK_EN: dbg_lock lets debug hold off the core.
module gpr_arbiter
  import gpr_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 8
) (
  input logic             clk,
  input logic             rst_n,
  gpr_arbiter_if.slave    bus
);

  state_e                state_q;
  logic [REG_ADDR_W-1:0] ra_q, rb_q, rd_q;
  logic [XLEN-1:0]       di_q;
  logic                  we_q;
  logic [XLEN-1:0]       core_qa_q, core_qb_q, dbg_rdata_q;
  logic                  core_rvalid_q, dbg_rvalid_q;
  logic                  at_max, preempt, core_ready, dbg_ready, hold_core;

`ifdef GPR_ARBITER_LOCK_EN
  logic lock_q;
  assign hold_core = lock_q;
`else
  assign hold_core = 1'b0;
`endif

  gpr_arbiter_starve #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (bus.dbg_valid && !dbg_ready),
    .clr_i    (dbg_ready || !bus.dbg_valid),
    .at_max_o (at_max)
  );

  // While locked, debug is granted even with core_valid high so it can unlock.
  always_comb begin
    preempt    = bus.dbg_valid && at_max;
    core_ready = bus.core_valid && !preempt && !hold_core;
    dbg_ready  = bus.dbg_valid && (!bus.core_valid || preempt || hold_core);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ra_q          <= '0;
      rb_q          <= '0;
      rd_q          <= '0;
      di_q          <= '0;
      we_q          <= 1'b0;
      core_qa_q     <= '0;
      core_qb_q     <= '0;
      dbg_rdata_q   <= '0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
`ifdef GPR_ARBITER_LOCK_EN
      lock_q        <= 1'b0;
`endif
    end else begin
      // Capture the read data of the transaction issued in this cycle.
      core_rvalid_q <= (state_q == StIssueCore);
      dbg_rvalid_q  <= (state_q == StIssueDbg);
      if (state_q == StIssueCore) begin
        core_qa_q <= (ra_q == REG_X0) ? '0 : bus.gpr_qa;
        core_qb_q <= (rb_q == REG_X0) ? '0 : bus.gpr_qb;
      end
      if (state_q == StIssueDbg) begin
        dbg_rdata_q <= (ra_q == REG_X0) ? '0 : bus.gpr_qa;
      end

      // Load the next issue; idle zeroes every gpr control.
      if (core_ready) begin
        state_q <= StIssueCore;
        ra_q    <= bus.core_ra;
        rb_q    <= bus.core_rb;
        rd_q    <= bus.core_rd;
        di_q    <= bus.core_wdata;
        we_q    <= bus.core_we;
      end else if (dbg_ready) begin
        state_q <= StIssueDbg;
        ra_q    <= bus.dbg_addr;
        rb_q    <= '0;
        rd_q    <= bus.dbg_addr;
        di_q    <= bus.dbg_wdata;
        we_q    <= bus.dbg_we;
      end else begin
        state_q <= StIdle;
        ra_q    <= '0;
        rb_q    <= '0;
        rd_q    <= '0;
        di_q    <= '0;
        we_q    <= 1'b0;
      end

`ifdef GPR_ARBITER_LOCK_EN
      if (dbg_ready) begin
        lock_q <= bus.dbg_lock;
      end
`endif
    end
  end

  assign bus.core_ready  = core_ready;
  assign bus.dbg_ready   = dbg_ready;
  assign bus.gpr_ra      = ra_q;
  assign bus.gpr_rb      = rb_q;
  assign bus.gpr_rd      = rd_q;
  assign bus.gpr_di      = di_q;
  // Writes to x0 never reach the register file.
  assign bus.gpr_we      = (state_q != StIdle) && we_q && (rd_q != REG_X0);
  assign bus.core_qa     = core_qa_q;
  assign bus.core_qb     = core_qb_q;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.dbg_rvalid  = dbg_rvalid_q;

endmodule

// File: tb/tb_gpr_arbiter.sv
module tb_gpr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpr_arbiter_if bus ();

  gpr_arbiter #(
    .STARVE_MAX (8),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file model: combinational read, write at the clock edge.
  logic [31:0] mem [32];
  assign bus.gpr_qa = mem[bus.gpr_ra];
  assign bus.gpr_qb = mem[bus.gpr_rb];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'hBAD0BAD0 : 32'h1000_0000 + i;
    end else if (bus.gpr_we) begin
      mem[bus.gpr_rd] <= bus.gpr_di;
    end
  end

  typedef struct {
    logic [31:0] qa;
    logic [31:0] qb;
    int          cyc;
  } exp_t;

  exp_t core_q[$];
  exp_t dbg_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.core_rvalid) begin
        if (core_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL core_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = core_q.pop_front();
          check("core_qa", bus.core_qa, e.qa);
          check("core_qb", bus.core_qb, e.qb);
          check("core_rvalid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.dbg_rvalid) begin
        if (dbg_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dbg_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = dbg_q.pop_front();
          check("dbg_rdata", bus.dbg_rdata, e.qa);
          check("dbg_rvalid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_req(input logic v, input logic we, input logic [4:0] ra,
                          input logic [4:0] rb, input logic [4:0] rd, input logic [31:0] wd);
    bus.core_valid = v;
    bus.core_we    = we;
    bus.core_ra    = ra;
    bus.core_rb    = rb;
    bus.core_rd    = rd;
    bus.core_wdata = wd;
  endtask

  task automatic dbg_req(input logic v, input logic we, input logic [4:0] addr,
                         input logic [31:0] wd);
    bus.dbg_valid = v;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wd;
  endtask

  task automatic push_core(input logic [31:0] qa, input logic [31:0] qb, input int c);
    exp_t e;
    e.qa = qa; e.qb = qb; e.cyc = c;
    core_q.push_back(e);
  endtask

  task automatic push_dbg(input logic [31:0] d, input int c);
    exp_t e;
    e.qa = d; e.qb = '0; e.cyc = c;
    dbg_q.push_back(e);
  endtask

  task automatic check_grant(input string name, input logic cr, input logic dr);
    @(negedge clk);
    check({name, "_core_ready"}, 32'(bus.core_ready), 32'(cr));
    check({name, "_dbg_ready"}, 32'(bus.dbg_ready), 32'(dr));
  endtask

  initial begin
    int c;
    core_req(0, 0, 0, 0, 0, 0);
    dbg_req(0, 0, 0, 0);
`ifdef GPR_ARBITER_LOCK_EN
    bus.dbg_lock = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_gpr_we", 32'(bus.gpr_we), 32'd0);
    check("rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
    check("rst_core_qa", bus.core_qa, 32'd0);
    rst_n = 1'b1;

    // Write x5 then read it back.
    step(); c = cyc;
    core_req(1, 1, 0, 0, 5, 32'hDEADBEEF);
    push_core(0, 0, c + 2);
    check_grant("wr_x5", 1, 0);
    step();
    core_req(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wr_x5_gpr_we", 32'(bus.gpr_we), 32'd1);
    check("wr_x5_gpr_rd", 32'(bus.gpr_rd), 32'd5);
    check("wr_x5_gpr_di", bus.gpr_di, 32'hDEADBEEF);
    step(); c = cyc;
    core_req(1, 0, 5, 0, 0, 0);
    push_core(32'hDEADBEEF, 0, c + 2);
    check_grant("rd_x5", 1, 0);
    step();
    core_req(0, 0, 0, 0, 0, 0);

    // x0 write suppressed, x0 read forced to zero.
    step(); c = cyc;
    core_req(1, 1, 0, 0, 0, 32'h12345678);
    push_core(0, 0, c + 2);
    step();
    core_req(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wr_x0_gpr_we", 32'(bus.gpr_we), 32'd0);
    step(); c = cyc;
    dbg_req(1, 0, 0, 0);
    push_dbg(0, c + 2);
    check_grant("dbg_rd_x0", 0, 1);
    step();
    dbg_req(0, 0, 0, 0);

    // Read-before-write and debug write returning the old value.
    step(); c = cyc;
    core_req(1, 1, 7, 3, 7, 32'hCAFEF00D);
    push_core(32'h1000_0007, 32'h1000_0003, c + 2);
    check_grant("rbw_wr", 1, 0);
    step(); c = cyc;
    core_req(1, 0, 7, 7, 0, 0);
    push_core(32'hCAFEF00D, 32'hCAFEF00D, c + 2);
    check_grant("rbw_rd", 1, 0);
    step(); c = cyc;
    core_req(0, 0, 0, 0, 0, 0);
    dbg_req(1, 1, 3, 32'h33);
    push_dbg(32'h1000_0003, c + 2);
    check_grant("dbg_wr_x3", 0, 1);
    step(); c = cyc;
    dbg_req(1, 0, 3, 0);
    push_dbg(32'h33, c + 2);
    step();
    dbg_req(0, 0, 0, 0);
    step();

    // Starvation: debug preempts exactly in its 9th waiting cycle (k = 8).
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        core_req(1, 0, 1, 2, 0, 0);
        dbg_req(1, 0, 9, 0);
      end
      if (k == 9) dbg_req(0, 0, 0, 0);
      c = cyc;
      if (k == 8) push_dbg(32'h1000_0009, c + 2);
      else push_core(32'h1000_0001, 32'h1000_0002, c + 2);
      check_grant($sformatf("starve_k%0d", k), (k != 8), (k == 8));
      step();
    end
    core_req(0, 0, 0, 0, 0, 0);
    step();

    // Simultaneous single requests: core first, debug next cycle.
    c = cyc;
    core_req(1, 0, 5, 0, 0, 0);
    dbg_req(1, 0, 7, 0);
    push_core(32'hDEADBEEF, 0, c + 2);
    push_dbg(32'hCAFEF00D, c + 3);
    check_grant("simul_c0", 1, 0);
    step();
    core_req(0, 0, 0, 0, 0, 0);
    check_grant("simul_c1", 0, 1);
    step();
    dbg_req(0, 0, 0, 0);
    step();

`ifdef GPR_ARBITER_LOCK_EN
    c = cyc;
    dbg_req(1, 0, 4, 0);
    bus.dbg_lock = 1'b1;
    push_dbg(32'h1000_0004, c + 2);
    check_grant("lock_set", 0, 1);
    step();
    dbg_req(0, 0, 0, 0);
    bus.dbg_lock = 1'b0;
    core_req(1, 0, 1, 2, 0, 0);
    for (int k = 0; k < 20; k++) begin
      check_grant($sformatf("locked_k%0d", k), 0, 0);
      step();
    end
    c = cyc;
    dbg_req(1, 0, 4, 0);
    push_dbg(32'h1000_0004, c + 2);
    check_grant("unlock", 0, 1);
    step(); c = cyc;
    dbg_req(0, 0, 0, 0);
    push_core(32'h1000_0001, 32'h1000_0002, c + 2);
    check_grant("unlocked_core", 1, 0);
    step();
    core_req(0, 0, 0, 0, 0, 0);
    repeat (3) step();
`endif

    // Reset during an ISSUE_CORE write.
    core_req(1, 1, 0, 0, 10, 32'hAAAA5555);
    check_grant("rst_wr", 1, 0);
    step();
    core_req(0, 0, 0, 0, 0, 0);
    #2;
    check("rst_pre_gpr_we", 32'(bus.gpr_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_gpr_we", 32'(bus.gpr_we), 32'd0);
    check("rst_async_gpr_rd", 32'(bus.gpr_rd), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_rvalid", 32'(bus.core_rvalid | bus.dbg_rvalid), 32'd0);
      check("post_rst_core_qa", bus.core_qa, 32'd0);
      check("post_rst_dbg_rdata", bus.dbg_rdata, 32'd0);
      check("post_rst_gpr_di", bus.gpr_di, 32'd0);
      step();
    end

    // Aborted write must not have landed in x10.
    c = cyc;
    core_req(1, 0, 10, 5, 0, 0);
    push_core(32'h1000_000A, 32'h1000_0005, c + 2);
    check_grant("post_rst_rd", 1, 0);
    step();
    core_req(0, 0, 0, 0, 0, 0);
    repeat (4) step();

    check("core_q_drained", 32'(core_q.size()), 32'd0);
    check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
